ext_ram_ctrl: RTL and testbench
===============================

# ext_ram_ctrl

Front-end controller for the single-port, synchronous-read external message RAM of the LDPC decoder. Shares the RAM's one access slot per cycle among N_REQ requesters (check-node units, variable-node units, LLR loader) with round-robin arbitration. Drives the RAM's cs/we/address/data_in pins and routes the one-cycle-latency read data back to the issuing requester. Optionally zero-fills the whole RAM after reset before accepting traffic.

## Interface
- DATA_WIDTH, 8, RAM word width
- ADDR_WIDTH, 8, RAM address width
- RAM_DEPTH, 1<<ADDR_WIDTH, number of words cleared by init
- N_REQ, 4, number of requesters (2..8)
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  N_REQ  per-requester access request
- req_we  in  N_REQ  1 = write, 0 = read
- req_addr  in  N_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  N_REQ*DATA_WIDTH  packed write data, same packing
- req_ready  out  N_REQ  one-hot grant; access is taken on the edge where valid&ready
- rsp_valid  out  N_REQ  one-hot read-data strobe
- rsp_data  out  DATA_WIDTH  read data, broadcast to all requesters
- init_done  out  1  high once the controller accepts requests
- ram_cs  out  1  to RAM cs
- ram_we  out  1  to RAM we
- ram_address  out  ADDR_WIDTH  to RAM address
- ram_data_in  out  DATA_WIDTH  to RAM data_in
- ram_data_out  in  DATA_WIDTH  from RAM data_out

## Operation
- States: INIT, RUN. Reset enters INIT (macro defined) or RUN (macro undefined).
- INIT: ram_cs=1, ram_we=1, ram_address=init_cnt, ram_data_in=0, req_ready=0. init_cnt counts 0..RAM_DEPTH-1; on the edge writing RAM_DEPTH-1, go to RUN, set init_done.
- RUN: arbiter picks the first i with req_valid[i], searching from rr_ptr upward, wrapping at N_REQ. req_ready[i] asserted combinationally; RAM pins driven combinationally from requester i: ram_cs=1, ram_we=req_we[i], address/data from slice i.
- After a grant to i: rr_ptr <= (i+1) mod N_REQ. No valid request: ram_cs=0, req_ready=0, rr_ptr holds.
- Requester must hold valid/we/addr/wdata stable while valid && !ready. Requesters must always accept responses (no response backpressure).
- Read grant to i registers rsp_id=i, rsp_valid <= one-hot(i); rsp_data = ram_data_out (passthrough). Write grant: rsp_valid <= 0.
- Write and read to same address by different requesters in the same cycle: serialized by arbitration; later read returns newly written data.
- Reset values: rsp_valid=0, init_done=0, rr_ptr=0, init_cnt=0. While rst_n=0: ram_cs=0, ram_we=0, req_ready=0 (gated combinationally).
- Reset mid-operation: in-flight read response discarded (rsp_valid 0 the cycle after reset), INIT restarts from address 0.

## Timing
- Grant and RAM issue: same cycle as request when selected (0-cycle arbitration).
- Read latency: access taken at edge N; rsp_valid/rsp_data valid in the cycle after edge N, for exactly one cycle.
- Throughput: one access per cycle total; with all requesters valid each gets 1 of every N_REQ cycles.
- INIT duration: RAM_DEPTH cycles after rst_n release; init_done high from cycle RAM_DEPTH (first grant possible that cycle).

## Configuration
- EXT_RAM_CTRL_INIT_EN defined: INIT state and init_cnt present; RAM zero-filled after every reset.
- Undefined: no INIT state or counter; init_done=1 from the first cycle after reset; grants possible immediately.

## Structure
- Package ext_ram_pkg: state typedef (INIT, RUN), N_REQ_MAX=8 constant, requester-id width function (clog2).
- Sub-module ext_ram_rr_arb: round-robin pointer register plus combinational one-hot grant; controller instantiates it and handles muxing, INIT and response tracking.

## Test plan
- Init (macro on, ADDR_WIDTH=8): release rst_n -> 256 cycles of ram_we=1, addresses 0..255, data 0, req_ready=0; init_done=1 at cycle 256.
- Single read: req 1 writes 0xA5 to 0x12, then reads 0x12 -> rsp_valid=4'b0010 next cycle, rsp_data=0xA5.
- Full contention: all 4 valid continuously -> req_ready sequence 0001,0010,0100,1000,0001; each read response to its issuer one cycle later.
- Same-cycle conflict: req 0 writes 0x3C to 0x05, req 1 reads 0x05, same cycle, rr_ptr=0 -> req 0 granted first, req 1 next cycle, rsp_data=0x3C.
- Idle hold: grant req 2, then no requests 5 cycles, then req 0 and req 3 valid -> req 3 granted first (rr_ptr=3 held).
- Reset mid-read: rst_n low in the cycle a read is granted -> rsp_valid=0 next cycle, ram_cs=0 during reset, rr_ptr=0, INIT restarts at address 0.

Source files
------------

// File: rtl/ext_ram_pkg.sv
// rtl/ext_ram_pkg.sv - shared types and helpers for the external message RAM controller
package ext_ram_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int N_REQ_MAX = 8;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ext_ram_rr_arb.sv
// rtl/ext_ram_rr_arb.sv - round-robin pointer with combinational one-hot grant
module ext_ram_rr_arb
    import ext_ram_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_grant_id,
    output logic             o_any
);

    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] w_sel;
    logic [ID_W-1:0] w_ptr_nxt;
    int              w_idx;

    // Scan from the pointer upward, wrapping at N_REQ; first valid requester wins.
    always_comb begin
        o_grant    = '0;
        o_grant_id = '0;
        o_any      = 1'b0;
        w_idx      = 0;
        w_sel      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            w_sel = ID_W'(w_idx);
            if (i_en && !o_any && i_req[w_sel]) begin
                o_any          = 1'b1;
                o_grant[w_sel] = 1'b1;
                o_grant_id     = w_sel;
            end
        end
    end

    assign w_ptr_nxt = (o_grant_id == ID_W'(N_REQ - 1)) ? '0 : o_grant_id + ID_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (o_any) begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule

// File: rtl/ext_ram_ctrl.sv
// rtl/ext_ram_ctrl.sv - arbitrated front end for the external message RAM
// Define EXT_RAM_CTRL_INIT_EN to zero-fill the RAM after every reset before granting requests.
module ext_ram_ctrl
    import ext_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int N_REQ      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ-1:0]            req_we,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_data,
    output logic                        init_done,
    output logic                        ram_cs,
    output logic                        ram_we,
    output logic [ADDR_WIDTH-1:0]       ram_address,
    output logic [DATA_WIDTH-1:0]       ram_data_in,
    input  logic [DATA_WIDTH-1:0]       ram_data_out
);

    localparam int ID_W = id_width(N_REQ);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_arb_en;
    logic                  w_any;
    logic [N_REQ-1:0]      w_grant;
    logic [ID_W-1:0]       w_grant_id;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic [N_REQ-1:0]      r_rsp_valid;
    logic [ADDR_WIDTH-1:0] w_init_addr;
    logic                  w_init_last;

`ifdef EXT_RAM_CTRL_INIT_EN
    localparam state_t RESET_STATE = INIT;

    logic [ADDR_WIDTH-1:0] r_init_cnt;

    assign w_init_addr = r_init_cnt;
    assign w_init_last = (r_init_cnt == ADDR_WIDTH'(RAM_DEPTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_init_cnt <= '0;
        end else if (r_state == INIT) begin
            r_init_cnt <= w_init_last ? '0 : r_init_cnt + ADDR_WIDTH'(1);
        end
    end
`else
    localparam state_t RESET_STATE = RUN;

    assign w_init_addr = '0;
    assign w_init_last = 1'b1;
`endif

    assign w_arb_en = rst_n && (r_state == RUN);

    ext_ram_rr_arb #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (w_arb_en),
        .i_req      (req_valid),
        .o_grant    (w_grant),
        .o_grant_id (w_grant_id),
        .o_any      (w_any)
    );

    assign w_sel_we    = req_we[w_grant_id];
    assign w_sel_addr  = req_addr[int'(w_grant_id) * ADDR_WIDTH +: ADDR_WIDTH];
    assign w_sel_wdata = req_wdata[int'(w_grant_id) * DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RESET_STATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        ram_cs      = 1'b0;
        ram_we      = 1'b0;
        ram_address = w_sel_addr;
        ram_data_in = w_sel_wdata;
        case (r_state)
            INIT: begin
                ram_cs      = 1'b1;
                ram_we      = 1'b1;
                ram_address = w_init_addr;
                ram_data_in = '0;
                if (w_init_last) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                ram_cs = w_any;
                ram_we = w_any & w_sel_we;
            end
            default: w_state_nxt = RESET_STATE;
        endcase
        // The RAM must see no strobe while reset is held, whatever the state register holds.
        if (!rst_n) begin
            ram_cs = 1'b0;
            ram_we = 1'b0;
        end
    end

    // The RAM's read data lands one cycle after issue, so only the issuer id is tracked.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_valid <= '0;
        end else begin
            r_rsp_valid <= (w_any && !w_sel_we) ? w_grant : '0;
        end
    end

    assign req_ready = w_grant;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = ram_data_out;
    assign init_done = rst_n && (r_state == RUN);

endmodule

// File: tb/tb_ext_ram_ctrl.sv
// tb/tb_ext_ram_ctrl.sv - randomized and directed self-checking bench for ext_ram_ctrl
module tb_ext_ram_ctrl;

    localparam int N     = 4;
    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;
`ifdef EXT_RAM_CTRL_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            init_done;
    logic            ram_cs;
    logic            ram_we;
    logic [AW-1:0]   ram_address;
    logic [DW-1:0]   ram_data_in;
    logic [DW-1:0]   ram_data_out;

    ext_ram_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RAM_DEPTH  (DEPTH),
        .N_REQ      (N)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .init_done    (init_done),
        .ram_cs       (ram_cs),
        .ram_we       (ram_we),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    always #5 clk = ~clk;

    // External synchronous-read RAM.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_rd = '0;
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) mem[ram_address] <= ram_data_in;
            else        ram_rd <= mem[ram_address];
        end
    end
    assign ram_data_out = ram_rd;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: round-robin pointer, shadow memory, pending response.
    logic [DW-1:0] ref_mem [DEPTH];
    int            m_ptr      = 0;
    logic [N-1:0]  m_rsp_v    = '0;
    logic [DW-1:0] m_rsp_d    = '0;
    bit            m_init     = INIT_EN;
    int            m_init_cnt = 0;

    always @(negedge clk) begin
        int            g;
        logic [N-1:0]  e_ready;
        logic          e_cs, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        if (chk_en) begin
            g = -1; e_ready = '0; e_cs = 0; e_we = 0; e_addr = '0; e_din = '0;
            if (rst_n && m_init) begin
                e_cs = 1; e_we = 1; e_addr = AW'(m_init_cnt);
            end else if (rst_n) begin
                for (int k = 0; k < N; k++)
                    if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                if (g >= 0) begin
                    e_ready[g] = 1; e_cs = 1; e_we = req_we[g];
                    e_addr = req_addr[g*AW +: AW]; e_din = req_wdata[g*DW +: DW];
                end
            end
            chk("m_req_ready", req_ready, e_ready);
            chk("m_ram_cs", ram_cs, e_cs);
            chk("m_ram_we", ram_we, e_we);
            if (e_cs) begin
                chk("m_ram_address", ram_address, e_addr);
                if (e_we) chk("m_ram_data_in", ram_data_in, e_din);
            end
            chk("m_rsp_valid", rsp_valid, m_rsp_v);
            if (m_rsp_v != 0) chk("m_rsp_data", rsp_data, m_rsp_d);
            chk("m_init_done", init_done, rst_n && !m_init);

            if (!rst_n) begin
                m_ptr = 0; m_rsp_v = '0; m_init = INIT_EN; m_init_cnt = 0;
            end else if (m_init) begin
                ref_mem[m_init_cnt] = '0;
                m_rsp_v = '0;
                if (m_init_cnt == DEPTH - 1) m_init = 0;
                else m_init_cnt++;
            end else if (g >= 0) begin
                m_ptr = (g + 1) % N;
                if (req_we[g]) begin
                    ref_mem[e_addr] = e_din;
                    m_rsp_v = '0;
                end else begin
                    m_rsp_v = '0;
                    m_rsp_v[g] = 1'b1;
                    m_rsp_d = ref_mem[e_addr];
                end
            end else begin
                m_rsp_v = '0;
            end
        end
    end

    task automatic set_req(input int i, input bit v, input bit we, input int a, input int d);
        req_valid[i]         = v;
        req_we[i]            = we;
        req_addr[i*AW +: AW] = AW'(a);
        req_wdata[i*DW +: DW] = DW'(d);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(input int exp_cycles);
        bit ok = 0;
        int n  = 0;
        for (int c = 0; c < DEPTH + 8; c++) begin
            @(negedge clk);
            if (init_done === 1'b1) begin ok = 1; break; end
            n++;
        end
        if (!ok) chk("init_timeout", 0, 1);
        else if (INIT_EN && exp_cycles >= 0) chk("init_cycles", n, exp_cycles);
    endtask

    logic [N-1:0] seq [5];
    logic [N-1:0] acc;

    initial begin
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = DW'(i * 7 + 3);
            ref_mem[i] = DW'(i * 7 + 3);
        end
        rst_n = 0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        step();
        chk_en = 1;
        step();
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_ram_cs", ram_cs, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_init_done", init_done, 0);
        step();
        rst_n = 1;
        wait_init(DEPTH);

        // Full contention from rr_ptr=0.
        step();
        for (int i = 0; i < N; i++) set_req(i, 1, 0, 8'h20 + i, 0);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("contention_grant", req_ready, seq[s]);
            acc = req_ready;
            step();
            for (int i = 0; i < N; i++) if (acc[i]) set_req(i, 1, 0, 8'h30 + s * 4 + i, 0);
        end
        req_valid = '0;

        // Single write then read by requester 1 (rr_ptr=1).
        set_req(1, 1, 1, 8'h12, 8'hA5);
        @(negedge clk);
        chk("wr_grant", req_ready, 4'b0010);
        chk("wr_ram_we", ram_we, 1);
        chk("wr_ram_address", ram_address, 8'h12);
        chk("wr_ram_data_in", ram_data_in, 8'hA5);
        step();
        set_req(1, 1, 0, 8'h12, 0);
        @(negedge clk);
        chk("rd_grant", req_ready, 4'b0010);
        chk("rd_ram_we", ram_we, 0);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("rd_rsp_valid", rsp_valid, 4'b0010);
        chk("rd_rsp_data", rsp_data, 8'hA5);

        // Grant requester 3 to bring rr_ptr back to 0, then same-cycle conflict.
        step();
        set_req(3, 1, 1, 8'h40, 8'h11);
        @(negedge clk);
        chk("ptr_wrap_grant", req_ready, 4'b1000);
        step();
        req_valid = '0;
        set_req(0, 1, 1, 8'h05, 8'h3C);
        set_req(1, 1, 0, 8'h05, 0);
        @(negedge clk);
        chk("conflict_first", req_ready, 4'b0001);
        step();
        req_valid[0] = 0;
        @(negedge clk);
        chk("conflict_second", req_ready, 4'b0010);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("conflict_rsp_valid", rsp_valid, 4'b0010);
        chk("conflict_rsp_data", rsp_data, 8'h3C);

        // Idle hold: pointer must stay at 3 across idle cycles.
        step();
        set_req(2, 1, 0, 8'h07, 0);
        @(negedge clk);
        chk("idle_pre_grant", req_ready, 4'b0100);
        step();
        req_valid = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("idle_ready", req_ready, 0);
            chk("idle_cs", ram_cs, 0);
            step();
        end
        set_req(0, 1, 0, 8'h01, 0);
        set_req(3, 1, 0, 8'h02, 0);
        @(negedge clk);
        chk("idle_hold_grant", req_ready, 4'b1000);
        step();
        req_valid[3] = 0;
        @(negedge clk);
        chk("idle_next_grant", req_ready, 4'b0001);
        step();
        req_valid = '0;

        // Reset asserted in the cycle a read would be granted.
        set_req(2, 1, 0, 8'h07, 0);
        rst_n = 0;
        @(negedge clk);
        chk("midrst_ready", req_ready, 0);
        chk("midrst_cs", ram_cs, 0);
        chk("midrst_we", ram_we, 0);
        step();
        rst_n = 1;
        for (int i = 0; i < N; i++) set_req(i, 1, 0, 8'h50 + i, 0);
        @(negedge clk);
        chk("midrst_rsp_valid", rsp_valid, 0);
        if (INIT_EN) begin
            chk("midrst_init_addr", ram_address, 0);
            chk("midrst_init_ready", req_ready, 0);
            wait_init(-1);
        end else begin
            chk("midrst_ptr_reset", req_ready, 4'b0001);
        end
        acc = req_valid & req_ready;

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            step();
            rst_n = ($urandom_range(0, 599) != 0);
            for (int i = 0; i < N; i++) begin
                if (acc[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 9) < 6)
                        set_req(i, 1, $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 255));
                    else
                        req_valid[i] = 0;
                end
            end
            @(negedge clk);
            acc = req_valid & req_ready;
        end

        step();
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
